intr_prio_ctrl: RTL and testbench

- Programmable priority interrupt controller that sits between the external interrupt lines and the single-cycle interrupt-capable MIPS core.
- Latches rising edges on the interrupt lines and applies a software mask.
- Resolves fixed priority with nesting, and presents one request plus a 3-bit vector to the core.
- Completes a request/acknowledge handshake, then tracks in-service levels until the core issues end-of-interrupt.

---
 rtl/intr_prio_ctrl.sv | 142 ++++++++++++++
 tb/tb_intr_prio_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_prio_ctrl.sv
// Priority interrupt controller: edge latch, mask, nested fixed priority.
// Ports: clk/reset, intr in, int_req/inta/vec/eoi to core, mask and status.
module intr_prio_ctrl #(
  parameter int                 NUM_IRQ  = 8,
  parameter int                 VEC_W    = 3,
  parameter logic [NUM_IRQ-1:0] MASK_RST = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] intr,
  output logic               int_req,
  input  logic               inta,
  output logic [VEC_W-1:0]   vec,
  input  logic               eoi,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic [NUM_IRQ-1:0] mask_q,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] in_service
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK
  } state_e;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] msk_q, msk_d;
  logic [NUM_IRQ-1:0] intr_d_q, intr_d_d;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic               cand_hit;
  logic [VEC_W-1:0]   cand_idx;
  logic               isr_hit;
  logic [VEC_W-1:0]   isr_idx;
  logic               cand_ok;
  logic               ack_fire;

  assign rise     = intr & ~intr_d_q;
  assign eligible = irr_q & ~msk_q;

  // Downward scans leave the lowest set index in the result.
  always_comb begin
    cand_hit = 1'b0;
    cand_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        cand_hit = 1'b1;
        cand_idx = VEC_W'(i);
      end
    end
  end

  always_comb begin
    isr_hit = 1'b0;
    isr_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (isr_q[i]) begin
        isr_hit = 1'b1;
        isr_idx = VEC_W'(i);
      end
    end
  end

  // Only a strictly higher priority than anything in service may nest.
  assign cand_ok  = cand_hit && (!isr_hit || (cand_idx < isr_idx));
  assign ack_fire = (state_q == REQ) && inta;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    int_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cand_ok) begin
          vec_d   = cand_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        int_req = 1'b1;
        if (inta) begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A new edge on the line being acknowledged re-arms it.
  always_comb begin
    irr_d = irr_q;
    isr_d = isr_q;
    if (eoi && isr_hit) begin
      isr_d[isr_idx] = 1'b0;
    end
    if (ack_fire) begin
      irr_d[vec_q] = 1'b0;
      isr_d[vec_q] = 1'b1;
    end
    irr_d = irr_d | rise;
  end

  always_comb begin
    msk_d    = mask_we ? mask_wdata : msk_q;
    intr_d_d = intr;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      irr_q    <= '0;
      isr_q    <= '0;
      msk_q    <= MASK_RST;
      intr_d_q <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      irr_q    <= irr_d;
      isr_q    <= isr_d;
      msk_q    <= msk_d;
      intr_d_q <= intr_d_d;
    end
  end

  assign vec        = vec_q;
  assign mask_q     = msk_q;
  assign pending    = irr_q;
  assign in_service = isr_q;

endmodule

// File: tb/tb_intr_prio_ctrl.sv
// Bench for intr_prio_ctrl: directed plan plus random traffic,
// scoreboarded against a per-cycle reference model.
module tb_intr_prio_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] intr;
  logic       int_req;
  logic       inta;
  logic [2:0] vec;
  logic       eoi;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic [7:0] mask_q;
  logic [7:0] pending;
  logic [7:0] in_service;

  always #5 clk = ~clk;

  intr_prio_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .intr       (intr),
    .int_req    (int_req),
    .inta       (inta),
    .vec        (vec),
    .eoi        (eoi),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask_q     (mask_q),
    .pending    (pending),
    .in_service (in_service)
  );

  typedef struct packed {
    logic       req;
    logic [2:0] vec;
    logic [7:0] mask;
    logic [7:0] irr;
    logic [7:0] isr;
  } obs_t;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [7:0] m_irr, m_isr, m_mask, m_prev;
  logic [2:0] m_vec;
  int         m_phase;

  function automatic int first_set(input logic [7:0] x);
    for (int i = 0; i < 8; i++) begin
      if (x[i]) return i;
    end
    return 8;
  endfunction

  task automatic model_tick(output obs_t e);
    logic [7:0] rise, n_irr, n_isr;
    int c, lo;
    if (!reset) begin
      m_irr = 0; m_isr = 0; m_mask = 8'hFF;
      m_prev = 0; m_phase = 0; m_vec = 0;
    end else begin
      rise  = intr & ~m_prev;
      c     = first_set(m_irr & ~m_mask);
      lo    = first_set(m_isr);
      n_irr = m_irr;
      n_isr = m_isr;
      if (eoi && lo < 8) n_isr[lo] = 1'b0;
      case (m_phase)
        0: if (c < lo) begin
          m_vec = c[2:0];
          m_phase = 1;
        end
        1: if (inta) begin
          n_irr[m_vec] = 1'b0;
          n_isr[m_vec] = 1'b1;
          m_phase = 2;
        end
        default: m_phase = 0;
      endcase
      m_irr  = n_irr | rise;
      m_isr  = n_isr;
      m_prev = intr;
      if (mask_we) m_mask = mask_wdata;
    end
    e.req  = (m_phase == 1);
    e.vec  = m_vec;
    e.mask = m_mask;
    e.irr  = m_irr;
    e.isr  = m_isr;
  endtask

  task automatic step();
    obs_t e;
    model_tick(e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    obs_t e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {int_req, vec, mask_q, pending, in_service};
      n_vec++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL cycle_obs t=%0t got req=%b vec=%0d mask=%h irr=%h isr=%h want req=%b vec=%0d mask=%h irr=%h isr=%h",
                 $time, g.req, g.vec, g.mask, g.irr, g.isr,
                 e.req, e.vec, e.mask, e.irr, e.isr);
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t got %h want %h", nm, $time, got, want);
    end
  endtask

  task automatic pulse(input logic [7:0] v);
    intr = v;
    step();
    intr = 8'h00;
  endtask

  task automatic wr_mask(input logic [7:0] v);
    mask_we = 1'b1;
    mask_wdata = v;
    step();
    mask_we = 1'b0;
  endtask

  task automatic do_inta();
    inta = 1'b1;
    step();
    inta = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    step();
    eoi = 1'b0;
  endtask

  task automatic wait_req();
    for (int n = 0; n < 12 && m_phase != 1; n++) step();
  endtask

  initial begin
    reset = 1'b0; intr = 0; inta = 0; eoi = 0;
    mask_we = 0; mask_wdata = 0;
    step();
    chk("rst_mask", mask_q, 8'hFF);
    chk("rst_req", {7'd0, int_req}, 8'h00);
    step();
    reset = 1'b1;

    // 1: single line
    wr_mask(8'h00);
    pulse(8'h04);
    chk("t1_irr", pending, 8'h04);
    chk("t1_req_early", {7'd0, int_req}, 8'h00);
    step();
    chk("t1_req", {7'd0, int_req}, 8'h01);
    chk("t1_vec", {5'd0, vec}, 8'h02);
    do_inta();
    chk("t1_isr", in_service, 8'h04);
    chk("t1_irr_clr", pending, 8'h00);
    chk("t1_req_low", {7'd0, int_req}, 8'h00);
    do_eoi();

    // 2: all lines, served in index order
    intr = 8'hFF;
    step();
    step();
    intr = 8'h00;
    for (int k = 0; k < 8; k++) begin
      wait_req();
      chk("t2_req", {7'd0, int_req}, 8'h01);
      chk("t2_vec", {5'd0, vec}, 8'(k));
      do_inta();
      step();
      step();
      chk("t2_hold", {7'd0, int_req}, 8'h00);
      do_eoi();
    end
    step();
    chk("t2_isr", in_service, 8'h00);
    chk("t2_irr", pending, 8'h00);

    // 3: nesting
    pulse(8'h20);
    wait_req();
    do_inta();
    chk("t3_isr5", in_service, 8'h20);
    pulse(8'h02);
    step();
    chk("t3_vec", {5'd0, vec}, 8'h01);
    do_inta();
    chk("t3_isr", in_service, 8'h22);
    do_eoi();
    chk("t3_eoi1", in_service, 8'h20);
    do_eoi();
    chk("t3_eoi2", in_service, 8'h00);

    // 4: masking
    wr_mask(8'h08);
    pulse(8'h08);
    step();
    step();
    chk("t4_irr", pending, 8'h08);
    chk("t4_noreq", {7'd0, int_req}, 8'h00);
    wr_mask(8'h00);
    step();
    chk("t4_vec", {5'd0, vec}, 8'h03);
    chk("t4_req", {7'd0, int_req}, 8'h01);
    do_inta();
    do_eoi();

    // 5: commitment
    pulse(8'h10);
    step();
    chk("t5_vec4", {5'd0, vec}, 8'h04);
    mask_we = 1'b1; mask_wdata = 8'h10; intr = 8'h01;
    step();
    mask_we = 1'b0; intr = 8'h00;
    step();
    chk("t5_hold_req", {7'd0, int_req}, 8'h01);
    chk("t5_hold_vec", {5'd0, vec}, 8'h04);
    do_inta();
    step();
    step();
    chk("t5_vec0", {5'd0, vec}, 8'h00);
    do_inta();
    do_eoi();
    do_eoi();
    wr_mask(8'h00);

    // 6: reset mid-request, stray inta, idle eoi
    pulse(8'h40);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("t6_req", {7'd0, int_req}, 8'h00);
    chk("t6_irr", pending, 8'h00);
    chk("t6_mask", mask_q, 8'hFF);
    do_inta();
    do_eoi();
    chk("t6_isr", in_service, 8'h00);

    // random traffic
    wr_mask(8'h00);
    for (int n = 0; n < 3000; n++) begin
      intr       = intr ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      inta       = (m_phase == 1) ? ($urandom_range(2) == 0)
                                  : ($urandom_range(15) == 0);
      eoi        = ($urandom_range(9) == 0);
      mask_we    = ($urandom_range(39) == 0);
      mask_wdata = 8'($urandom) & 8'($urandom);
      reset      = ($urandom_range(299) != 0);
      step();
    end
    reset = 1'b1; inta = 0; eoi = 0; mask_we = 0;

    for (int n = 0; n < 4 && exp_q.size() > 0; n++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain left %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
